// File: rtl/mult_int4b_top.sv
`default_nettype none
// ============================================================================
// Module   : mult_int4b_top
// Brief    : Two-stage signed constant-coefficient multiplier with optional
//            low-order truncation (floor to a multiple of 2^APPROX_LSBS).
// Revision : 1.0
// ============================================================================
module mult_int4b_top #(
    parameter int BIT_WIDTH   = 4,
    parameter int OUT_WIDTH   = 2 * BIT_WIDTH,
    parameter int COEF        = 5,
    parameter int APPROX_LSBS = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [BIT_WIDTH-1:0] inp,
    input  logic                 in_valid,
    output logic [OUT_WIDTH-1:0] out,
    output logic                 out_valid
);

    localparam logic [BIT_WIDTH-1:0] c_coef_bits = COEF[BIT_WIDTH-1:0];
    localparam logic [OUT_WIDTH-1:0] c_keep_mask = {OUT_WIDTH{1'b1}} << APPROX_LSBS;

    logic [BIT_WIDTH-1:0] inp_q;
    logic                 vld1_q;
    logic [OUT_WIDTH-1:0] prod_q;
    logic [OUT_WIDTH-1:0] prod_d;
    logic                 vld2_q;

    logic [OUT_WIDTH-1:0] w_inp_ext;
    logic [OUT_WIDTH-1:0] w_acc [BIT_WIDTH+1];

    assign w_inp_ext = {{(OUT_WIDTH-BIT_WIDTH){inp_q[BIT_WIDTH-1]}}, inp_q};
    assign w_acc[0]  = '0;

    // Modulo-2^OUT_WIDTH accumulation is exact because the product always fits.
    for (genvar j = 0; j < BIT_WIDTH; j++) begin : g_row
        if (c_coef_bits[j]) begin : g_keep
            if (j == BIT_WIDTH - 1) begin : g_neg
                assign w_acc[j+1] = w_acc[j] - (w_inp_ext << j);
            end else begin : g_pos
                assign w_acc[j+1] = w_acc[j] + (w_inp_ext << j);
            end
        end else begin : g_prune
            assign w_acc[j+1] = w_acc[j];
        end
    end

    // Clearing low bits of a two's-complement value floors it toward -inf.
    assign prod_d = w_acc[BIT_WIDTH] & c_keep_mask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inp_q  <= '0;
            vld1_q <= 1'b0;
            prod_q <= '0;
            vld2_q <= 1'b0;
        end else begin
            inp_q  <= inp;
            vld1_q <= in_valid;
            prod_q <= prod_d;
            vld2_q <= vld1_q;
        end
    end

    assign out       = prod_q;
    assign out_valid = vld2_q;

endmodule
`default_nettype wire

// File: tb/tb_mult_int4b_top.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_int4b_top
// Brief    : Scoreboard bench driving 13 parameter variants of mult_int4b_top.
// Revision : 1.0
// ============================================================================
module tb_mult_int4b_top;

    localparam int c_ncfg = 13;

    function automatic int cfg_coef(input int i);
        case (i % 6)
            0:       cfg_coef = -8;
            1:       cfg_coef = -1;
            2:       cfg_coef = 0;
            3:       cfg_coef = 1;
            4:       cfg_coef = 5;
            default: cfg_coef = 7;
        endcase
        if (i == 12) cfg_coef = 5;
    endfunction

    function automatic int cfg_approx(input int i);
        if (i < 6)       cfg_approx = 0;
        else if (i < 12) cfg_approx = 3;
        else             cfg_approx = 2;
    endfunction

    function automatic logic [7:0] model(input logic [3:0] x, input int c, input int a);
        int p;
        p = int'($signed(x)) * c;
        p = (p >>> a) <<< a;
        return 8'(p);
    endfunction

    typedef struct packed {
        logic                  v;
        logic [c_ncfg-1:0][7:0] d;
    } exp_t;

    logic       clk = 1'b0;
    logic       r_rst_n;
    logic [3:0] r_inp;
    logic       r_valid;
    logic [7:0] w_out [c_ncfg];
    logic       w_vld [c_ncfg];

    exp_t q_exp[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < c_ncfg; g++) begin : g_dut
        mult_int4b_top #(
            .BIT_WIDTH  (4),
            .OUT_WIDTH  (8),
            .COEF       (cfg_coef(g)),
            .APPROX_LSBS(cfg_approx(g))
        ) u_dut (
            .clk      (clk),
            .rst_n    (r_rst_n),
            .inp      (r_inp),
            .in_valid (r_valid),
            .out      (w_out[g]),
            .out_valid(w_vld[g])
        );
    end

    task automatic check_out();
        exp_t e;
        if (q_exp.size() >= 2) e = q_exp.pop_front();
        else e = '0;
        for (int i = 0; i < c_ncfg; i++) begin
            n_cmp++;
            assert (w_vld[i] === e.v) else begin
                n_err++;
                $error("FAIL out_valid cfg%0d: observed %b expected %b", i, w_vld[i], e.v);
            end
            if (e.v) begin
                n_cmp++;
                assert (w_out[i] === e.d[i]) else begin
                    n_err++;
                    $error("FAIL out cfg%0d (coef %0d, approx %0d): observed %h expected %h",
                           i, cfg_coef(i), cfg_approx(i), w_out[i], e.d[i]);
                end
            end
        end
    endtask

    task automatic check_reset_zero();
        for (int i = 0; i < c_ncfg; i++) begin
            n_cmp++;
            assert (w_vld[i] === 1'b0 && w_out[i] === 8'h00) else begin
                n_err++;
                $error("FAIL reset cfg%0d: observed vld=%b out=%h expected vld=0 out=00",
                       i, w_vld[i], w_out[i]);
            end
        end
    endtask

    // Called on a falling edge: check, drive, then advance one cycle.
    task automatic step(input logic v, input logic [3:0] x);
        exp_t e;
        check_out();
        r_valid = v;
        r_inp   = x;
        if (r_rst_n) begin
            e.v = v;
            for (int i = 0; i < c_ncfg; i++) e.d[i] = model(x, cfg_coef(i), cfg_approx(i));
            q_exp.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic assert_reset();
        r_rst_n = 1'b0;
        #1;
        q_exp.delete();
        check_reset_zero();
    endtask

    initial begin
        r_rst_n = 1'b0;
        r_inp   = 4'd3;
        r_valid = 1'b1;
        #1;
        check_reset_zero();
        repeat (3) begin
            @(negedge clk);
            check_reset_zero();
        end

        r_rst_n = 1'b1;
        step(1'b1, 4'd3);
        step(1'b1, 4'd7);
        step(1'b1, 4'h8);
        step(1'b1, 4'hF);
        step(1'b1, 4'd0);

        step(1'b1, 4'd2);
        step(1'b0, 4'(($urandom)));
        step(1'b1, 4'hE);

        step(1'b1, 4'h8);
        step(1'b1, 4'd7);
        step(1'b0, 4'd0);
        step(1'b0, 4'd0);

        for (int k = 0; k < 16; k++) begin
            if (k == 9) begin
                assert_reset();
                step(1'b1, 4'd5);
                step(1'b1, 4'd6);
                check_reset_zero();
                r_rst_n = 1'b1;
            end
            step(1'b1, 4'(k));
        end
        for (int k = 15; k >= 0; k--) step(1'b1, 4'(k));
        repeat (3) step(1'b0, 4'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
